// File: rtl/ad9244_emu.sv
// AD9244 output-bus emulator: pattern generator, clamp/OTR, latency pipe, burst FSM.
// Define ADC_EMU_DITHER_EN to add LFSR[1:0] dither to constant and ramp modes.
module ad9244_emu #(
    parameter int DATA_W   = 14,
    parameter int PIPE_LAT = 8,
    parameter int SQ_HALF  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [15:0]       burst_len,
    output logic [DATA_W-1:0] Data_O,
    output logic              OTR_O,
    output logic              valid_O,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] M_CONST  = 2'd0;
    localparam logic [1:0] M_RAMP   = 2'd1;
    localparam logic [1:0] M_SQUARE = 2'd2;
    localparam logic [1:0] M_LFSR   = 2'd3;
    localparam int RAW_W = DATA_W + 2;
    localparam int PW    = DATA_W + 2;
    localparam logic [RAW_W-1:0] RAW_MAX   = {2'b00, {DATA_W{1'b1}}};
    localparam logic [3:0]       FLUSH_LAST = 4'(PIPE_LAT - 1);
    localparam logic [15:0]      SQ_LAST    = 16'(SQ_HALF - 1);

    logic [1:0]                   state_q, state_d, mode_q, mode_d;
    logic [15:0]                  cnt_q, cnt_d, sq_cnt_q, sq_cnt_d;
    logic [DATA_W:0]              acc_q, acc_d;
    logic                         sq_hi_q, sq_hi_d;
    logic [14:0]                  lfsr_q, lfsr_d, lfsr_nxt_s;
    logic [3:0]                   fcnt_q, fcnt_d;
    logic [PIPE_LAT-1:0][PW-1:0]  pipe_q, pipe_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         fire_s, otr_s;
    logic [RAW_W-1:0]             raw_s;
    logic [DATA_W-1:0]            sample_s;

    // Raw pattern value for the current sample and its clamp to the converter range.
    always_comb begin
        lfsr_nxt_s = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        case (mode_q)
            M_CONST:  raw_s = RAW_W'(const_val);
            M_RAMP:   raw_s = RAW_W'(acc_q);
            M_SQUARE: raw_s = sq_hi_q ? RAW_W'(const_val) : {RAW_W{1'b0}};
            M_LFSR:   raw_s = RAW_W'(lfsr_nxt_s);
            default:  raw_s = {RAW_W{1'b0}};
        endcase
`ifdef ADC_EMU_DITHER_EN
        if (mode_q == M_CONST || mode_q == M_RAMP) begin
            raw_s = raw_s + RAW_W'(lfsr_q[1:0]);
        end else begin
            raw_s = raw_s;
        end
`endif
        if (raw_s > RAW_MAX) begin
            sample_s = {DATA_W{1'b1}};
            otr_s    = 1'b1;
        end else begin
            sample_s = raw_s[DATA_W-1:0];
            otr_s    = 1'b0;
        end
    end

    // Burst FSM, generator state update and latency pipe next-state.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sq_cnt_d = sq_cnt_q;
        sq_hi_d  = sq_hi_q;
        lfsr_d   = lfsr_q;
        fcnt_d   = fcnt_q;
        fire_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mode_d   = mode;
                    cnt_d    = 16'd0;
                    acc_d    = {(DATA_W+1){1'b0}};
                    sq_cnt_d = 16'd0;
                    sq_hi_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                fire_s = en;
                if (en) begin
                    cnt_d = cnt_q + 16'd1;
                    if (mode_q == M_RAMP) begin
                        acc_d = acc_q + {{DATA_W{1'b0}}, 1'b1};
                    end else begin
                        acc_d = acc_q;
                    end
                    if (mode_q == M_SQUARE && sq_cnt_q == SQ_LAST) begin
                        sq_cnt_d = 16'd0;
                        sq_hi_d  = ~sq_hi_q;
                    end else if (mode_q == M_SQUARE) begin
                        sq_cnt_d = sq_cnt_q + 16'd1;
                    end else begin
                        sq_cnt_d = sq_cnt_q;
                    end
`ifdef ADC_EMU_DITHER_EN
                    lfsr_d = lfsr_nxt_s;
`else
                    if (mode_q == M_LFSR) begin
                        lfsr_d = lfsr_nxt_s;
                    end else begin
                        lfsr_d = lfsr_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q;
                end
                if (stop || (en && burst_len != 16'd0 && (cnt_q + 16'd1) == burst_len)) begin
                    state_d = S_FLUSH;
                    fcnt_d  = 4'd0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pipe_d[0] = {fire_s, otr_s, sample_s};
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        // Output stage keeps the last bus value when no valid sample arrives.
        pipe_d[PIPE_LAT-1] = pipe_d[PIPE_LAT-1][PW-1] ? pipe_d[PIPE_LAT-1]
                                                     : {1'b0, pipe_q[PIPE_LAT-1][PW-2:0]};
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FLUSH) && (fcnt_d == FLUSH_LAST);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            cnt_q    <= 16'd0;
            acc_q    <= {(DATA_W+1){1'b0}};
            sq_cnt_q <= 16'd0;
            sq_hi_q  <= 1'b1;
            lfsr_q   <= 15'h0001;
            fcnt_q   <= 4'd0;
            pipe_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sq_cnt_q <= sq_cnt_d;
            sq_hi_q  <= sq_hi_d;
            lfsr_q   <= lfsr_d;
            fcnt_q   <= fcnt_d;
            pipe_q   <= pipe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Data_O  = pipe_q[PIPE_LAT-1][DATA_W-1:0];
    assign OTR_O   = pipe_q[PIPE_LAT-1][DATA_W];
    assign valid_O = pipe_q[PIPE_LAT-1][PW-1];
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_ad9244_emu.sv
// Directed bench for ad9244_emu with a cycle-stamped scoreboard of expected bus samples.
module tb_ad9244_emu;
    localparam int LAT = 8;
    localparam int SQH = 16;

    logic        clk = 1'b0;
    logic        rst, start, stop, en;
    logic [1:0]  mode;
    logic [13:0] const_val;
    logic [15:0] burst_len;
    logic [13:0] Data_O;
    logic        OTR_O, valid_O, busy, done;

    ad9244_emu dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode),
        .const_val(const_val), .burst_len(burst_len), .Data_O(Data_O), .OTR_O(OTR_O),
        .valid_O(valid_O), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] d;
        logic        o;
        int          c;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    logic [13:0] last_d = 14'd0;
    logic        last_o = 1'b0;
    int exp_done = -1;
    int busy_lo  = 1;
    int busy_hi  = 0;
    logic mon_en = 1'b0;

    int          m_state;
    logic [15:0] m_cnt;
    logic [14:0] m_acc, m_lfsr;
    int          m_sq_cnt;
    logic        m_sq_hi;
    logic [1:0]  m_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        last_d = 14'd0; last_o = 1'b0;
        exp_done = -1; busy_lo = 1; busy_hi = 0;
        m_state = 0; m_cnt = 16'd0; m_acc = 15'd0; m_lfsr = 15'h0001;
        m_sq_cnt = 0; m_sq_hi = 1'b1; m_mode = 2'd0;
    endtask

    task automatic gen_push();
        logic [15:0] r;
        exp_t e;
        case (m_mode)
            2'd0: r = {2'b00, const_val};
            2'd1: begin r = {1'b0, m_acc}; m_acc = m_acc + 15'd1; end
            2'd2: begin
                r = m_sq_hi ? {2'b00, const_val} : 16'd0;
                if (m_sq_cnt == SQH - 1) begin m_sq_cnt = 0; m_sq_hi = ~m_sq_hi; end
                else m_sq_cnt++;
            end
            default: begin
                m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
                r = {1'b0, m_lfsr};
            end
        endcase
        if (r > 16'd16383) begin e.d = 14'h3FFF; e.o = 1'b1; end
        else begin e.d = r[13:0]; e.o = 1'b0; end
        e.c = cyc + LAT;
        sb.push_back(e);
        m_cnt = m_cnt + 16'd1;
    endtask

    // Drive one cycle of inputs and advance the reference burst model.
    task automatic cycle(input logic s, input logic e, input logic p);
        start = s; en = e; stop = p;
        case (m_state)
            0: if (s) begin
                m_state = 1; m_mode = mode; m_cnt = 16'd0; m_acc = 15'd0;
                m_sq_cnt = 0; m_sq_hi = 1'b1;
                busy_lo = cyc + 1; busy_hi = 2147483647;
            end
            1: begin
                if (e) gen_push();
                if (p || (e && burst_len != 16'd0 && m_cnt == burst_len)) begin
                    m_state = 2; exp_done = cyc + LAT; busy_hi = cyc + LAT;
                end
            end
            default: if (cyc == exp_done) m_state = 0;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (m_state == 0) break;
            cycle(1'b0, 1'b1, 1'b0);
        end
        chk("model_idle", 32'(m_state), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison of the bus against the scoreboard and handshake expectations.
    always @(negedge clk) begin : mon
        logic exp_v;
        exp_t e;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].c == cyc);
            n_assert++;
            assert (valid_O === exp_v) else begin
                n_fail++;
                $error("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_O, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                last_d = e.d;
                last_o = e.o;
            end
            n_assert++;
            assert (Data_O === last_d) else begin
                n_fail++;
                $error("FAIL data cyc=%0d got=%h exp=%h", cyc, Data_O, last_d);
            end
            n_assert++;
            assert (OTR_O === last_o) else begin
                n_fail++;
                $error("FAIL otr cyc=%0d got=%b exp=%b", cyc, OTR_O, last_o);
            end
            n_assert++;
            assert (done === (cyc == exp_done)) else begin
                n_fail++;
                $error("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cyc == exp_done);
            end
            n_assert++;
            assert (busy === (cyc >= busy_lo && cyc <= busy_hi)) else begin
                n_fail++;
                $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc >= busy_lo && cyc <= busy_hi));
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
        mode = 2'd0; const_val = 14'd0; burst_len = 16'd0;
        model_reset();
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Ramp burst of 4: values 0..3 after the pipeline latency, then done.
        mode = 2'd1; burst_len = 16'd4;
        cycle(1'b1, 1'b1, 1'b0);
        wait_idle();

        // Constant burst of 3 with a two-cycle enable gap.
        mode = 2'd0; const_val = 14'h1234; burst_len = 16'd3;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        wait_idle();

        // Continuous ramp through the clamp region and the 15-bit wrap, then stop.
        mode = 2'd1; burst_len = 16'd0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32770; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        wait_idle();

        // Square wave, 64 samples, with a stray start while busy.
        mode = 2'd2; const_val = 14'h2000; burst_len = 16'd64;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) cycle(logic'(i == 10), 1'b1, 1'b0);
        wait_idle();

        // LFSR burst: seed 1 gives 2, 4, 8 ... and OTR tracks state bit 14.
        mode = 2'd3; burst_len = 16'd40;
        cycle(1'b1, 1'b0, 1'b0);
        wait_idle();

        // Asynchronous reset in the middle of a burst while valid_O is high.
        mode = 2'd1; burst_len = 16'd20;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("valid_before_rst", 32'(valid_O), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_data", 32'(Data_O), 32'd0);
        chk("rst_otr", 32'(OTR_O), 32'd0);
        chk("rst_valid", 32'(valid_O), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Post-reset bursts behave as from cold reset (ramp from 0, LFSR reseeded).
        mode = 2'd1; burst_len = 16'd4;
        cycle(1'b1, 1'b0, 1'b0);
        wait_idle();
        mode = 2'd3; burst_len = 16'd3;
        cycle(1'b1, 1'b0, 1'b0);
        wait_idle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
